// File: rtl/warp_state_tracker_if.sv
// Event/status bundle between the compute-unit front end (master) and the
// warp state tracker (slave).
interface warp_state_tracker_if #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_W    = 2,
    parameter int LAT_W     = 4
);
    logic                 launch;
    logic [NUM_WARPS-1:0] warp_mask;
    logic                 issue_valid;
    logic [WARP_W-1:0]    issue_warp;
    logic [1:0]           issue_kind;
    logic [LAT_W-1:0]     issue_lat;
    logic                 mem_resp_valid;
    logic [WARP_W-1:0]    mem_resp_warp;
    logic                 matmul_done;
    logic [NUM_WARPS-1:0] ready_warps;
    logic                 run;
    logic                 all_done;
    logic                 err_illegal;

    modport master (
        output launch, warp_mask, issue_valid, issue_warp, issue_kind, issue_lat,
               mem_resp_valid, mem_resp_warp, matmul_done,
        input  ready_warps, run, all_done, err_illegal
    );

    modport slave (
        input  launch, warp_mask, issue_valid, issue_warp, issue_kind, issue_lat,
               mem_resp_valid, mem_resp_warp, matmul_done,
        output ready_warps, run, all_done, err_illegal
    );
endinterface

// File: rtl/warp_state_tracker.sv
// Per-warp IDLE/READY/wait state table producing ready_warps for the warp selector.
// Optional feature macro WARP_STALL_CNT_EN adds a saturating stall_cycles output.
module warp_state_tracker #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_W    = 2,
    parameter int LAT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef WARP_STALL_CNT_EN
    output logic [15:0] stall_cycles,
`endif
    warp_state_tracker_if.slave bus
);

    typedef enum logic [2:0] {
        WS_IDLE     = 3'd0,
        WS_READY    = 3'd1,
        WS_ALU_BUSY = 3'd2,
        WS_MEM_WAIT = 3'd3,
        WS_MM_WAIT  = 3'd4,
        WS_DONE     = 3'd5
    } warp_state_t;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'b00,
        KIND_MEM    = 2'b01,
        KIND_EXIT   = 2'b10,
        KIND_MATMUL = 2'b11
    } issue_kind_t;

    warp_state_t          state_q   [NUM_WARPS];
    warp_state_t          state_nxt [NUM_WARPS];
    logic [LAT_W-1:0]     cnt_q     [NUM_WARPS];
    logic [LAT_W-1:0]     cnt_nxt   [NUM_WARPS];
    logic [NUM_WARPS-1:0] ready_q, ready_nxt;
    logic                 run_q, run_nxt;
    logic                 done_q, done_nxt;
    logic                 err_q, err_nxt;
    logic                 quiescent;
    logic                 launch_ok;
    issue_kind_t          kind;

    assign launch_ok = bus.launch && !run_q;
    assign kind      = issue_kind_t'(bus.issue_kind);

    // A running kernel is finished once no warp is READY or waiting on anything.
    always_comb begin
        quiescent = run_q;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (state_q[i] != WS_IDLE && state_q[i] != WS_DONE) quiescent = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        run_nxt   = run_q;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        ready_nxt = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
        end

        if (launch_ok) begin
            run_nxt = 1'b1;
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_nxt[i] = bus.warp_mask[i] ? WS_READY : WS_IDLE;
                cnt_nxt[i]   = '0;
            end
        end else begin
            if (bus.launch) err_nxt = 1'b1;

            // Each event only acts on warps in one specific current state, so they never overlap.
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (state_q[i] == WS_ALU_BUSY) begin
                    if (cnt_q[i] <= LAT_W'(1)) begin
                        state_nxt[i] = WS_READY;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt_q[i] - LAT_W'(1);
                    end
                end
                if (bus.matmul_done && state_q[i] == WS_MM_WAIT) state_nxt[i] = WS_READY;
            end

            if (bus.mem_resp_valid) begin
                if (state_q[bus.mem_resp_warp] == WS_MEM_WAIT)
                    state_nxt[bus.mem_resp_warp] = WS_READY;
                else
                    err_nxt = 1'b1;
            end

            if (bus.issue_valid) begin
                if (run_q && state_q[bus.issue_warp] == WS_READY) begin
                    case (kind)
                        KIND_ALU: begin
                            if (bus.issue_lat != '0) begin
                                state_nxt[bus.issue_warp] = WS_ALU_BUSY;
                                cnt_nxt[bus.issue_warp]   = bus.issue_lat;
                            end
                        end
                        KIND_MEM:    state_nxt[bus.issue_warp] = WS_MEM_WAIT;
                        KIND_EXIT:   state_nxt[bus.issue_warp] = WS_DONE;
                        KIND_MATMUL: state_nxt[bus.issue_warp] = WS_MM_WAIT;
                    endcase
                end else begin
                    err_nxt = 1'b1;
                end
            end

            if (quiescent) begin
                run_nxt  = 1'b0;
                done_nxt = 1'b1;
                for (int i = 0; i < NUM_WARPS; i++) begin
                    if (state_q[i] == WS_DONE) state_nxt[i] = WS_IDLE;
                end
            end
        end

        for (int i = 0; i < NUM_WARPS; i++) ready_nxt[i] = (state_nxt[i] == WS_READY);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the warp table is a few flops, not RAM, and must read IDLE straight after reset, so it is reset.
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= WS_IDLE;
                cnt_q[i]   <= '0;
            end
            ready_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
            ready_q <= ready_nxt;
            run_q   <= run_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.ready_warps = ready_q;
    assign bus.run         = run_q;
    assign bus.all_done    = done_q;
    assign bus.err_illegal = err_q;

`ifdef WARP_STALL_CNT_EN
    logic [15:0] stall_q;

    // Starved cycles: kernel in flight but nothing ready; value is kept after completion.
    always_ff @(posedge clk) begin
        if (reset || launch_ok)
            stall_q <= '0;
        else if (run_q && ready_q == '0 && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule
